// File: rtl/sprite_ram_writer.sv
// Sprite image loader: unpacks 2-bit pixels from host bytes and drives the
// write port of the sprite RAM, one pixel per clock in raster order.
module sprite_ram_writer #(
  parameter int WIDTH  = 110,
  parameter int HEIGHT = 59,
  parameter int ADDR_W = 13
) (
  input  logic              pixel_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        wr_data,
  output logic              busy,
  output logic              done
);

  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(WIDTH * HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [ADDR_W-1:0] pix_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        slot_q;
  logic [7:0]        byte_q;
  logic              take_byte;

  // abort outranks a byte arriving in the same cycle
  assign take_byte = (state_q == FETCH) && byte_valid && !abort;

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every variable in a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = FETCH;
      FETCH: begin
        if (abort)          state_d = IDLE;
        else if (take_byte) state_d = WRITE;
      end
      WRITE: begin
        if (abort)                       state_d = IDLE;
        else if (pix_cnt_q == PIX_LAST)  state_d = DONE;
        else if (slot_q == 2'd3)         state_d = FETCH;
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      col_q     <= '0;
      row_q     <= '0;
      pix_cnt_q <= '0;
      addr_q    <= '0;
      slot_q    <= '0;
      byte_q    <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        col_q     <= '0;
        row_q     <= '0;
        pix_cnt_q <= '0;
        addr_q    <= '0;
      end
      if (take_byte) begin
        byte_q <= byte_in;
        slot_q <= '0;
      end
      if (state_q == WRITE) begin
        slot_q    <= slot_q + 2'd1;
        pix_cnt_q <= pix_cnt_q + 1'b1;
        addr_q    <= addr_q + 1'b1;
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  // Outputs decode registers only, so no input reaches an output combinationally.
  assign byte_ready = (state_q == FETCH);
  assign wr_en      = (state_q == WRITE);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign wr_addr    = addr_q;

  always_comb begin
    wr_data = byte_q[7:6];
    unique case (slot_q)
      2'd0: wr_data = byte_q[7:6];
      2'd1: wr_data = byte_q[5:4];
      2'd2: wr_data = byte_q[3:2];
      2'd3: wr_data = byte_q[1:0];
      default: wr_data = byte_q[7:6];
    endcase
  end

endmodule

// File: tb/tb_sprite_ram_writer.sv
// Directed bench for sprite_ram_writer: handshake, raster addressing, row wrap,
// full-image termination, backpressure, abort and asynchronous reset.
module tb_sprite_ram_writer;

  localparam int WIDTH  = 110;
  localparam int HEIGHT = 59;
  localparam int ADDR_W = 13;

  logic              pixel_clk = 1'b0;
  logic              reset, start, abort, byte_valid;
  logic [7:0]        byte_in;
  logic              byte_ready, wr_en, busy, done;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        wr_data;

  int checks   = 0;
  int failures = 0;

  // Reference model of the raster position and run statistics
  int pix, mcol, mrow, done_cnt, cyc, last_wr_cyc, done_cyc, sent;

  sprite_ram_writer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)) dut (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    logic       start;
    logic       valid;
    logic [7:0] din;
    logic       exp_ready;
    logic       exp_wr_en;
    int         exp_addr;
    logic [1:0] exp_data;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pixel_clk);
    #1;
    cyc++;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    pix = 0; mcol = 0; mrow = 0; done_cnt = 0; sent = 0;
    last_wr_cyc = -1; done_cyc = -1;
  endtask

  // Drives up to nbytes bytes for ncyc cycles and checks every write against
  // the raster model; optionally withholds byte_valid for stall_len FETCH cycles
  // once stall_at bytes have been sent.
  task automatic stream(input int nbytes, input int ncyc, input logic use_fill,
                        input logic [7:0] fill, input int stall_at, input int stall_len);
    int stalled = 0;
    logic stall_fetch;
    logic xfer;
    logic [7:0] v;
    for (int c = 0; c < ncyc; c++) begin
      stall_fetch = 1'b0;
      byte_in     = use_fill ? fill : 8'(sent);
      byte_valid  = (sent < nbytes);
      if (sent == stall_at && stalled < stall_len) begin
        byte_valid = 1'b0;
        if (byte_ready) begin
          stalled++;
          stall_fetch = 1'b1;
        end
      end
      xfer = byte_ready && byte_valid;
      step();
      if (xfer) sent++;
      if (stall_fetch) begin
        check("stall_ready", int'(byte_ready), 1);
        check("stall_wr_en", int'(wr_en), 0);
      end
      if (wr_en) begin
        v = use_fill ? fill : 8'(pix / 4);
        check("wr_addr", int'(wr_addr), mrow * WIDTH + mcol);
        check("wr_data", int'(wr_data), int'((v >> (6 - 2 * (pix % 4))) & 8'h03));
        pix++;
        mcol++;
        if (mcol == WIDTH) begin
          mcol = 0;
          mrow++;
        end
        last_wr_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    byte_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    pix = 0; mcol = 0; mrow = 0; done_cnt = 0; cyc = 0; sent = 0;
    last_wr_cyc = -1; done_cyc = -1;

    // Basic single byte, including a start pulse during WRITE that must be ignored
    vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 2'd0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'hE4, 1'b0, 1'b1, 0, 2'd3, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1, 2'd2, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2, 2'd1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3, 2'd0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 2'd0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 2'd0, 1'b1, 1'b0};

    step();
    step();
    check("rst_ready", int'(byte_ready), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_addr",  int'(wr_addr), 0);
    check("rst_data",  int'(wr_data), 0);
    check("rst_busy",  int'(busy), 0);
    check("rst_done",  int'(done), 0);
    reset = 1'b0;
    step();
    check("idle_ready", int'(byte_ready), 0);

    for (int i = 0; i < 7; i++) begin
      start      = vecs[i].start;
      byte_valid = vecs[i].valid;
      byte_in    = vecs[i].din;
      step();
      start = 1'b0;
      check($sformatf("vec%0d_ready", i), int'(byte_ready), int'(vecs[i].exp_ready));
      check($sformatf("vec%0d_wr_en", i), int'(wr_en),      int'(vecs[i].exp_wr_en));
      check($sformatf("vec%0d_busy", i),  int'(busy),       int'(vecs[i].exp_busy));
      check($sformatf("vec%0d_done", i),  int'(done),       int'(vecs[i].exp_done));
      if (vecs[i].exp_wr_en) begin
        check($sformatf("vec%0d_addr", i), int'(wr_addr), vecs[i].exp_addr);
        check($sformatf("vec%0d_data", i), int'(wr_data), int'(vecs[i].exp_data));
      end
    end

    // Abort from FETCH returns to IDLE
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_fetch_busy", int'(busy), 0);

    // Row wrap: bytes 0..27, byte 27 (0x1B) covers addresses 108..111
    do_start();
    stream(28, 28 * 5 + 2, 1'b0, 8'h00, -1, 0);
    check("wrap_pix",  pix, 112);
    check("wrap_row",  mrow, 1);
    check("wrap_done", done_cnt, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;

    // Backpressure: 7 idle FETCH cycles after byte 3, address sequence continues
    do_start();
    stream(6, 6 * 5 + 7 + 2, 1'b0, 8'h00, 3, 7);
    check("bp_pix", pix, 24);
    abort = 1'b1;
    step();
    abort = 1'b0;

    // Full image with byte_valid held high
    do_start();
    stream(1623, 1623 * 5 + 4, 1'b1, 8'hFF, -1, 0);
    check("full_writes",   pix, WIDTH * HEIGHT);
    check("full_bytes",    sent, 1623);
    check("full_done_cnt", done_cnt, 1);
    check("full_done_at",  done_cyc, last_wr_cyc + 1);
    check("full_busy",     int'(busy), 0);
    check("full_addr_end", (mrow * WIDTH + mcol) - 1, 6489);

    // Abort in the second WRITE cycle of byte 5
    do_start();
    stream(5, 22, 1'b0, 8'h00, -1, 0);
    check("abort_pix_pre", pix, 18);
    check("abort_wr_pre",  int'(wr_en), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_wr_en", int'(wr_en), 0);
    check("abort_busy",  int'(busy), 0);
    check("abort_ready", int'(byte_ready), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_quiet_wr", int'(wr_en), 0);
      check("abort_quiet_done", int'(done), 0);
    end

    // Asynchronous reset between edges during WRITE
    do_start();
    stream(2, 7, 1'b0, 8'h00, -1, 0);
    check("arst_wr_pre", int'(wr_en), 1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_wr_en", int'(wr_en), 0);
    check("arst_busy",  int'(busy), 0);
    check("arst_ready", int'(byte_ready), 0);
    check("arst_addr",  int'(wr_addr), 0);
    step();
    reset = 1'b0;
    step();
    do_start();
    stream(1, 6, 1'b0, 8'hC6, -1, 0);
    check("arst_restart_pix", pix, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_ram_writer.md
Name: sprite_ram_writer

Overview:
Loads 2-bit colour-index sprite images into the dual-port sprite image RAM. The sprite display blobs read that RAM by pixel address (column + row*WIDTH), and this block owns the write port. Packed bytes arrive from the host/serial link through a valid/ready handshake. Each byte is unpacked into four pixels, and one pixel is written per clock in raster order. The block signals done after exactly WIDTH*HEIGHT pixels.

Parameters:
WIDTH, 110, sprite width in pixels
HEIGHT, 59, sprite height in pixels
ADDR_W, 13, RAM address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT

Ports:
pixel_clk  input  1  system pixel clock; all state changes on its rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse that begins a load; honoured only in IDLE
abort  input  1  single-cycle pulse; terminates a load in progress
byte_in  input  8  four packed pixels; bits [7:6] are the first pixel, [1:0] the last
byte_valid  input  1  byte_in is valid
byte_ready  output  1  block accepts byte_in this cycle
wr_en  output  1  RAM write strobe
wr_addr  output  ADDR_W  RAM write address (row*WIDTH + col)
wr_data  output  2  colour index to write
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the final pixel has been written

Behaviour:
- Reset is asynchronous and active-high. It forces state IDLE and drives byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0. It clears col, row, pix_cnt, slot and the byte latch.
- All outputs are registered or decoded from state registers only; there is no combinational path from any input to any output.
- A handshake transfer occurs on a cycle where byte_valid && byte_ready. byte_in is sampled only in that cycle.
- State IDLE: byte_ready=0. On start, clear col, row, pix_cnt and the address, then go to FETCH.
- State FETCH: byte_ready=1, wr_en=0. On transfer, latch byte_in, set slot=0 and go to WRITE. Without a transfer, stay in FETCH indefinitely.
- State WRITE: byte_ready=0, wr_en=1. wr_data = latched byte bits [7-2*slot : 6-2*slot] and wr_addr = current address. Each cycle:
  - slot increments.
  - col increments; when col reaches WIDTH-1, col returns to 0 and row increments.
  - The address increments by 1; it must always equal row*WIDTH + col, and the bench checks this invariant.
  - pix_cnt increments.
- Leaving WRITE:
  - After slot 3, return to FETCH.
  - When the pixel written is the final one (pix_cnt = WIDTH*HEIGHT-1), go to DONE immediately, whatever the slot. Remaining pixels in that byte are discarded.
  - With the defaults, 6490 pixels take 1623 bytes, and only the top two pixels of the last byte are written.
- State DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- Throughput is one byte per 5 cycles when the source holds byte_valid high continuously. The latency from transfer to the first write is 1 cycle.
- start outside IDLE is ignored.
- abort in FETCH or WRITE goes to IDLE on the next edge. No further wr_en is asserted and done is not pulsed. abort takes priority over a simultaneous transfer or state transition. abort in IDLE or DONE is ignored, so DONE still pulses.
- A write already issued before abort is not undone. Partial images remain in RAM.
- Reset asserted mid-load behaves like abort, plus it clears all registers immediately (asynchronously).

Test Plan:
- Basic: reset, start, send 0xE4 → four writes on consecutive cycles: (addr 0, data 3), (1, 2), (2, 1), (3, 0); byte_ready low during those cycles, high again in the 5th.
- Row wrap: stream bytes 0..27. The 28th byte (0x1B) writes addr 108 col 108 row 0, then addr 109, then addr 110 with col 0 row 1, then addr 111. The address matches row*WIDTH + col every cycle.
- Full image: stream 1623 bytes of 0xFF with byte_valid held high. Expect exactly 6490 wr_en cycles, last wr_addr = 6489, and done pulses once in the cycle after that write. The last byte's low 4 bits are never written; busy then drops.
- Backpressure: hold byte_valid low for 7 cycles in FETCH → no writes, byte_ready stays 1, and counters hold. Resume → writes continue at the next address with no gap in the address sequence.
- Abort / ignore: assert abort in the 2nd WRITE cycle of byte 5 → wr_en falls next cycle, no done pulse, busy=0. start asserted during WRITE is ignored, and the address sequence is unaffected.
- Async reset: assert reset mid-WRITE between clock edges → wr_en, busy and byte_ready drop immediately. The next start writes from addr 0.
